// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows an external Hack ALU.
// Drives the ALU operands and control bits only while busy is high.
module alu_mul_sequencer #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Hack ALU control words {zx,nx,zy,ny,f,no}
    localparam logic [5:0] CTRL_ZERO = 6'b101010;
    localparam logic [5:0] CTRL_ADD  = 6'b000010;
    localparam logic [5:0] CTRL_PASS = 6'b001010;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DBL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mplier_nxt;
    logic [WIDTH-1:0] mplier_shr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] product_nxt;
    logic             last_iter;

    assign mplier_shr = mplier >> 1;
    assign cnt_inc    = cnt + CW'(1);
    assign last_iter  = (cnt_inc == CW'(WIDTH))
                      || (EARLY_EXIT && (mplier_shr == '0));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            cnt     <= cnt_nxt;
            product <= product_nxt;
        end
    end

    // Product is loaded on entry to DONE so it is already valid
    // during the done pulse and stays put afterwards.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        cnt_nxt     = cnt;
        product_nxt = product;
        alu_x       = '0;
        alu_y       = '0;
        alu_ctrl    = CTRL_ZERO;

        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt    = '0;
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    cnt_nxt    = '0;
                    if (EARLY_EXIT && (b == '0)) begin
                        state_nxt   = DONE;
                        product_nxt = '0;
                    end else begin
                        state_nxt = ADD;
                    end
                end
            end
            ADD: begin
                alu_x     = acc;
                alu_y     = mcand;
                alu_ctrl  = mplier[0] ? CTRL_ADD : CTRL_PASS;
                acc_nxt   = alu_out;
                state_nxt = DBL;
            end
            DBL: begin
                alu_x      = mcand;
                alu_y      = mcand;
                alu_ctrl   = CTRL_ADD;
                mcand_nxt  = alu_out;
                mplier_nxt = mplier_shr;
                cnt_nxt    = cnt_inc;
                if (last_iter) begin
                    state_nxt   = DONE;
                    product_nxt = acc;
                end else begin
                    state_nxt = ADD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: two sequencers (early exit on/off), each beside a
// behavioural Hack ALU, checked against hand-computed products.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  start;
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [15:0] product [2];
    logic [15:0] alu_x [2];
    logic [15:0] alu_y [2];
    logic [5:0]  alu_ctrl [2];
    logic [15:0] alu_out [2];

    int total;
    int bad;

    function automatic logic [15:0] hack(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic [5:0]  c);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] r;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) r = ~r;
        return r;
    endfunction

    assign alu_out[0] = hack(alu_x[0], alu_y[0], alu_ctrl[0]);
    assign alu_out[1] = hack(alu_x[1], alu_y[1], alu_ctrl[1]);

    // index 0: always WIDTH iterations, index 1: early exit
    alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_full (
        .clk      (clk),
        .reset    (reset),
        .start    (start[0]),
        .a        (a[0]),
        .b        (b[0]),
        .busy     (busy[0]),
        .done     (done[0]),
        .product  (product[0]),
        .alu_x    (alu_x[0]),
        .alu_y    (alu_y[0]),
        .alu_ctrl (alu_ctrl[0]),
        .alu_out  (alu_out[0])
    );

    alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_early (
        .clk      (clk),
        .reset    (reset),
        .start    (start[1]),
        .a        (a[1]),
        .b        (b[1]),
        .busy     (busy[1]),
        .done     (done[1]),
        .product  (product[1]),
        .alu_x    (alu_x[1]),
        .alu_y    (alu_y[1]),
        .alu_ctrl (alu_ctrl[1]),
        .alu_out  (alu_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat = edges after the accepting edge until done is seen
    task automatic run_mul(input int u,
                           input logic [15:0] av,
                           input logic [15:0] bv,
                           output logic [15:0] prod,
                           output int lat,
                           output bit to);
        bit found;
        @(negedge clk);
        start[u] = 1'b1;
        a[u] = av;
        b[u] = bv;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        a[u] = ~av;
        b[u] = ~bv;
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done[u] === 1'b1) begin
                found = 1'b1;
                break;
            end
            lat++;
        end
        to = !found;
        prod = product[u];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (busy[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy u=%0d got=%b exp=0", u, busy[u]);
            end
            total++;
            if (done[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_done u=%0d got=%b exp=0", u, done[u]);
            end
            total++;
            if (product[u] !== 16'h0) begin
                bad++;
                $display("FAIL reset_product u=%0d got=%h exp=0000", u, product[u]);
            end
            total++;
            if (alu_x[u] !== 16'h0 || alu_y[u] !== 16'h0) begin
                bad++;
                $display("FAIL reset_xy u=%0d got=%h/%h exp=0000/0000",
                         u, alu_x[u], alu_y[u]);
            end
            total++;
            if (alu_ctrl[u] !== 6'b101010) begin
                bad++;
                $display("FAIL reset_ctrl u=%0d got=%b exp=101010", u, alu_ctrl[u]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_t1_sequence();
        logic [5:0] seq [6];
        seq[0] = 6'b000010;
        seq[1] = 6'b000010;
        seq[2] = 6'b001010;
        seq[3] = 6'b000010;
        seq[4] = 6'b000010;
        seq[5] = 6'b000010;
        @(negedge clk);
        start[1] = 1'b1;
        a[1] = 16'd3;
        b[1] = 16'd5;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (alu_ctrl[1] !== seq[i] || busy[1] !== 1'b1 || done[1] !== 1'b0) begin
                bad++;
                $display("FAIL t1_ctrl step=%0d got=%b busy=%b done=%b exp=%b busy=1 done=0",
                         i, alu_ctrl[1], busy[1], done[1], seq[i]);
            end
            if (i == 0) begin
                total++;
                if (alu_x[1] !== 16'd0 || alu_y[1] !== 16'd3) begin
                    bad++;
                    $display("FAIL t1_add0_xy got=%h/%h exp=0000/0003", alu_x[1], alu_y[1]);
                end
            end
            if (i == 1) begin
                total++;
                if (alu_x[1] !== 16'd3 || alu_y[1] !== 16'd3) begin
                    bad++;
                    $display("FAIL t1_dbl0_xy got=%h/%h exp=0003/0003", alu_x[1], alu_y[1]);
                end
            end
            if (i == 4) begin
                total++;
                if (alu_x[1] !== 16'd3 || alu_y[1] !== 16'd12) begin
                    bad++;
                    $display("FAIL t1_add2_xy got=%h/%h exp=0003/000c", alu_x[1], alu_y[1]);
                end
            end
        end
        @(negedge clk);
        total++;
        if (done[1] !== 1'b1 || product[1] !== 16'd15) begin
            bad++;
            $display("FAIL t1_done got done=%b product=%h exp done=1 product=000f",
                     done[1], product[1]);
        end
        @(negedge clk);
        total++;
        if (done[1] !== 1'b0 || busy[1] !== 1'b0 || product[1] !== 16'd15) begin
            bad++;
            $display("FAIL t1_after got done=%b busy=%b product=%h exp 0 0 000f",
                     done[1], busy[1], product[1]);
        end
    endtask

    task automatic test_t2_negative();
        logic [15:0] p;
        int lat;
        bit to;
        run_mul(0, 16'hFFFF, 16'd2, p, lat, to);
        total++;
        if (to || p !== 16'hFFFE || lat != 32) begin
            bad++;
            $display("FAIL t2_full got product=%h lat=%0d timeout=%b exp fffe 32 0", p, lat, to);
        end
        run_mul(1, 16'hFFFF, 16'd2, p, lat, to);
        total++;
        if (to || p !== 16'hFFFE || lat != 4) begin
            bad++;
            $display("FAIL t2_early got product=%h lat=%0d timeout=%b exp fffe 4 0", p, lat, to);
        end
    endtask

    task automatic test_t3_wrap();
        logic [15:0] p;
        int lat;
        bit to;
        run_mul(1, 16'd300, 16'd300, p, lat, to);
        total++;
        if (to || p !== 16'h5F90 || lat != 18) begin
            bad++;
            $display("FAIL t3_300sq got product=%h lat=%0d timeout=%b exp 5f90 18 0", p, lat, to);
        end
        run_mul(1, 16'd0, 16'hFFFF, p, lat, to);
        total++;
        if (to || p !== 16'h0 || lat != 32) begin
            bad++;
            $display("FAIL t3_zero_a got product=%h lat=%0d timeout=%b exp 0000 32 0", p, lat, to);
        end
        run_mul(0, 16'd300, 16'd300, p, lat, to);
        total++;
        if (to || p !== 16'h5F90 || lat != 32) begin
            bad++;
            $display("FAIL t3_full got product=%h lat=%0d timeout=%b exp 5f90 32 0", p, lat, to);
        end
    endtask

    task automatic test_t4_zero_b();
        logic [15:0] p;
        int lat;
        bit to;
        run_mul(1, 16'd5, 16'd7, p, lat, to);
        total++;
        if (to || p !== 16'd35 || lat != 6) begin
            bad++;
            $display("FAIL t4_pre got product=%h lat=%0d timeout=%b exp 0023 6 0", p, lat, to);
        end
        run_mul(1, 16'd5, 16'd0, p, lat, to);
        total++;
        if (to || p !== 16'h0 || lat != 0) begin
            bad++;
            $display("FAIL t4_early got product=%h lat=%0d timeout=%b exp 0000 0 0", p, lat, to);
        end
        run_mul(0, 16'd5, 16'd0, p, lat, to);
        total++;
        if (to || p !== 16'h0 || lat != 32) begin
            bad++;
            $display("FAIL t4_full got product=%h lat=%0d timeout=%b exp 0000 32 0", p, lat, to);
        end
    endtask

    task automatic test_t5_start_busy();
        bit gap;
        gap = 1'b0;
        @(negedge clk);
        start[1] = 1'b1;
        a[1] = 16'd6;
        b[1] = 16'd7;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy[1] !== 1'b1 || done[1] !== 1'b0) gap = 1'b1;
            if (i == 2) begin
                start[1] = 1'b1;
                a[1] = 16'd100;
                b[1] = 16'd100;
            end
            if (i == 3) start[1] = 1'b0;
        end
        total++;
        if (gap) begin
            bad++;
            $display("FAIL t5_busy got=broken exp=unbroken");
        end
        @(negedge clk);
        total++;
        if (done[1] !== 1'b1 || product[1] !== 16'd42) begin
            bad++;
            $display("FAIL t5_result got done=%b product=%h exp done=1 product=002a",
                     done[1], product[1]);
        end
        @(negedge clk);
        total++;
        if (busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL t5_not_queued got busy=%b exp=0", busy[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat;
        bit to;
        run_mul(1, 16'd7, 16'd9, p, lat, to);
        total++;
        if (to || p !== 16'd63 || lat != 8) begin
            bad++;
            $display("FAIL b2b_first got product=%h lat=%0d timeout=%b exp 003f 8 0", p, lat, to);
        end
        run_mul(1, 16'd11, 16'd13, p, lat, to);
        total++;
        if (to || p !== 16'd143 || lat != 8) begin
            bad++;
            $display("FAIL b2b_second got product=%h lat=%0d timeout=%b exp 008f 8 0", p, lat, to);
        end
    endtask

    task automatic test_t6_reset_mid();
        logic [15:0] p;
        int lat;
        bit to;
        bit seen;
        run_mul(0, 16'd7, 16'd9, p, lat, to);
        total++;
        if (to || p !== 16'd63 || lat != 32) begin
            bad++;
            $display("FAIL t6_pre got product=%h lat=%0d timeout=%b exp 003f 32 0", p, lat, to);
        end
        @(negedge clk);
        start[0] = 1'b1;
        a[0] = 16'd7;
        b[0] = 16'd9;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b1 || alu_ctrl[0] !== 6'b001010) begin
            bad++;
            $display("FAIL t6_iter7 got busy=%b ctrl=%b exp busy=1 ctrl=001010",
                     busy[0], alu_ctrl[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || product[0] !== 16'h0
            || alu_ctrl[0] !== 6'b101010) begin
            bad++;
            $display("FAIL t6_reset got busy=%b done=%b product=%h ctrl=%b exp 0 0 0000 101010",
                     busy[0], done[0], product[0], alu_ctrl[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL t6_quiet got=activity exp=idle");
        end
        run_mul(0, 16'd7, 16'd9, p, lat, to);
        total++;
        if (to || p !== 16'd63 || lat != 32) begin
            bad++;
            $display("FAIL t6_fresh got product=%h lat=%0d timeout=%b exp 003f 32 0", p, lat, to);
        end
    endtask

    task automatic test_reset_wins();
        @(negedge clk);
        reset = 1'b1;
        start[1] = 1'b1;
        a[1] = 16'd3;
        b[1] = 16'd5;
        @(negedge clk);
        reset = 1'b0;
        start[1] = 1'b0;
        total++;
        if (busy[1] !== 1'b0 || product[1] !== 16'h0) begin
            bad++;
            $display("FAIL reset_wins got busy=%b product=%h exp busy=0 product=0000",
                     busy[1], product[1]);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        start = 2'b00;
        a[0] = '0;
        a[1] = '0;
        b[0] = '0;
        b[1] = '0;
        test_reset();
        test_t1_sequence();
        test_t2_negative();
        test_t3_wrap();
        test_t4_zero_b();
        test_t5_start_busy();
        test_back_to_back();
        test_t6_reset_mid();
        test_reset_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
